mem_bist_ctrl: RTL and testbench
================================

Name: mem_bist_ctrl

Overview:
- Upstream sequencer for the small register-cell RAMs (2^ADDR_W x DATA_W, e.g. the 2x8 array).
- Drives the RAM's r_w, address and data_in ports and reads back data_out.
- Runs a 3-element march test: ascending write P; ascending read P then write ~P; descending read ~P.
- Reports pass/fail, an error count, and the first failing address and data.

Parameters:
- ADDR_W, 1, RAM address width; DEPTH = 2^ADDR_W.
- DATA_W, 8, RAM word width.
- PATTERN, 8'hAA, background pattern P (DATA_W bits); ~P is its bitwise inverse.

Ports:
- clk  in  1  clock; RAM shares the same clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  level-sampled request; acted on only in IDLE or DONE.
- busy  out  1  high while a test runs.
- done  out  1  high from test completion until the next accepted start.
- pass  out  1  valid when done=1; 1 = zero mismatches.
- err_count  out  ADDR_W+2  mismatch count, saturating at all-ones.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_data  out  DATA_W  data read at the first mismatch.
- fail_exp  out  DATA_W  expected data at the first mismatch.
- ram_r_w  out  1  1 = write, 0 = read.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data; valid after the negedge of a read cycle, X during write cycles.

Behaviour:
- Reset: all outputs 0 (ram_r_w=0, ram_addr=0, ram_din=0, busy=0, done=0, pass=0, err_count=0, fail_*=0); state IDLE.
  - rst also clears RAM cells; the test does not rely on that.
- RAM timing contract:
  - RAM writes at the posedge ending a cycle with ram_r_w=1.
  - RAM output updates at the mid-cycle negedge when ram_r_w=0.
  - The controller samples ram_dout only at the posedge ending a read cycle.
  - The controller never samples after a write cycle.
- All RAM-facing outputs are registered; they change only at posedge.
- States: IDLE, W0, R0, W1, R1, FLUSH, DONE.
- IDLE/DONE + start=1 at edge t0:
  - enter W0 at addr 0; busy=1, done=0, pass=0.
  - clear err_count and fail_*.
- W0: ram_r_w=1, ram_din=P. Address increments each cycle; after DEPTH-1, go to R0 at addr 0.
- R0 (read) -> W1 (write ~P, same addr):
  - At the R0->W1 edge, compare ram_dout with P.
  - W1 increments the address and returns to R0.
  - After W1 at DEPTH-1, go to R1 at addr DEPTH-1.
- R1: one read per cycle, address descending.
  - Each edge compares the sampled ram_dout with ~P, tagged with the previous cycle's address (1-deep pipeline register).
  - After reading addr 0, go to FLUSH.
- FLUSH:
  - Compares the last read; ram_r_w=0, ram_addr=0.
  - Next edge goes to DONE: busy=0, done=1, pass=(err_count==0 including that final compare).
- Latency: done rises at edge t0+4*DEPTH+1 (DEPTH=2: 9 cycles).
- Mismatch handling:
  - err_count increments, saturating.
  - fail_addr/fail_data/fail_exp are captured only on the first mismatch of a run.
- start while busy: ignored; no restart.
- start held high in DONE: a new run starts on the next edge.
- rst mid-run: immediate IDLE; all results cleared.
- Address arithmetic: ADDR_W bits, no wrap used. Terminal detection uses compare to DEPTH-1 (ascending) or 0 (descending).

Decomposition:
- Package mem_bist_pkg:
  - state enum encoding (3-bit localparams);
  - default PATTERN;
  - the function computing err_count width (ADDR_W+2).
- Sub-module mem_bist_addr_gen:
  - ADDR_W counter with load-zero, load-max, inc, dec;
  - flags at_max and at_zero.

Test Plan:
- Good RAM, ADDR_W=1, PATTERN=AA.
  - Stimulus: start pulse at t0.
  - Write sequence: W AA@0, W AA@1, R@0, W 55@0, R@1, W 55@1, R@1, R@0.
  - Response: done=1 at t0+9, pass=1, err_count=0.
- Stuck-at-0 bit 7 on cell 1 (faulty RAM model).
  - First mismatch in R0: fail_addr=1, fail_exp=AA, fail_data=2A.
  - Response: err_count=1, pass=0.
  - Note: R1 expects 55 and reads 55, so no second error.
- Cell 0 stuck at 8'h00.
  - Response: fail_addr=0, fail_exp=AA, fail_data=00, err_count=2 (R0 and R1).
- Restart behaviour.
  - start held high through the run: no restart while busy.
  - Second run begins the cycle after DONE; err_count and fail_* cleared at its start.
- Mid-run reset.
  - rst at t0+4 (inside R0/W1).
  - Response: all outputs 0 asynchronously, state IDLE; a following start completes with pass=1.
- Parameter sweep.
  - ADDR_W=3, PATTERN=8'h3C, good RAM.
  - Response: done at t0+33, pass=1.
  - R1 addresses observed 7 down to 0; no sampling after any write cycle.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST controller.
package mem_bist_pkg;

    // Default background pattern P; the march test also uses ~P.
    localparam logic [7:0] DEFAULT_PATTERN = 8'hAA;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_W0    = 3'd1,
        ST_R0    = 3'd2,
        ST_W1    = 3'd3,
        ST_R1    = 3'd4,
        ST_FLUSH = 3'd5,
        ST_DONE  = 3'd6
    } bist_state_e;

    // The error counter is two bits wider than the address, so the
    // 2*DEPTH compares of one run can never saturate it.
    function automatic int unsigned err_cnt_w(input int unsigned addr_w);
        return addr_w + 2;
    endfunction

endpackage

// File: rtl/mem_bist_addr_gen.sv
// Address counter for the BIST march: load-zero, load-max, increment, decrement.
module mem_bist_addr_gen
    import mem_bist_pkg::*;
#(
    parameter int unsigned ADDR_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_zero,
    input  logic              ld_max,
    input  logic              inc,
    input  logic              dec,
    output logic [ADDR_W-1:0] addr,
    output logic              at_max,
    output logic              at_zero
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    // Next address; loads take priority over counting.
    always_comb begin
        addr_d = addr_q;
        if (ld_zero) begin
            addr_d = '0;
        end else if (ld_max) begin
            addr_d = '1;
        end else if (inc) begin
            addr_d = addr_q + 1'b1;
        end else if (dec) begin
            addr_d = addr_q - 1'b1;
        end
    end

    // Address register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr    = addr_q;
    assign at_max  = (addr_q == '1);
    assign at_zero = (addr_q == '0);

endmodule

// File: rtl/mem_bist_ctrl.sv
// March-test BIST sequencer for small register-cell RAMs:
// ascending write P; ascending read P / write ~P; descending read ~P.
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 1,
    parameter int unsigned       DATA_W  = 8,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEFAULT_PATTERN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [err_cnt_w(ADDR_W)-1:0] err_count,
    output logic [ADDR_W-1:0]            fail_addr,
    output logic [DATA_W-1:0]            fail_data,
    output logic [DATA_W-1:0]            fail_exp,
    output logic                         ram_r_w,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic [DATA_W-1:0]            ram_din,
    input  logic [DATA_W-1:0]            ram_dout
);

    localparam int unsigned ERR_W = err_cnt_w(ADDR_W);

    bist_state_e       state_q, state_d;
    logic              ram_r_w_q, ram_r_w_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
    // Descending-read pipeline: sample at one edge, compare at the next.
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

    logic              ag_ld_zero, ag_ld_max, ag_inc, ag_dec;
    logic [ADDR_W-1:0] cur_addr;
    logic              at_max, at_zero;

    logic              cmp_en;
    logic [DATA_W-1:0] cmp_data, cmp_exp;
    logic [ADDR_W-1:0] cmp_addr;

    mem_bist_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .ld_zero (ag_ld_zero),
        .ld_max  (ag_ld_max),
        .inc     (ag_inc),
        .dec     (ag_dec),
        .addr    (cur_addr),
        .at_max  (at_max),
        .at_zero (at_zero)
    );

    // Next-state, RAM command, compare and result bookkeeping.
    always_comb begin
        state_d     = state_q;
        ram_r_w_d   = 1'b0;
        ram_din_d   = '0;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        fail_exp_d  = fail_exp_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        rd_addr_d   = rd_addr_q;
        ag_ld_zero  = 1'b0;
        ag_ld_max   = 1'b0;
        ag_inc      = 1'b0;
        ag_dec      = 1'b0;
        cmp_en      = 1'b0;
        cmp_data    = ram_dout;
        cmp_exp     = PATTERN;
        cmp_addr    = cur_addr;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_W0;
                    ag_ld_zero  = 1'b1;
                    ram_r_w_d   = 1'b1;
                    ram_din_d   = PATTERN;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_d       = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    fail_exp_d  = '0;
                end
            end
            ST_W0: begin
                if (at_max) begin
                    state_d    = ST_R0;
                    ag_ld_zero = 1'b1;
                end else begin
                    ag_inc    = 1'b1;
                    ram_r_w_d = 1'b1;
                    ram_din_d = PATTERN;
                end
            end
            ST_R0: begin
                cmp_en    = 1'b1;
                state_d   = ST_W1;
                ram_r_w_d = 1'b1;
                ram_din_d = ~PATTERN;
            end
            ST_W1: begin
                if (at_max) begin
                    state_d   = ST_R1;
                    ag_ld_max = 1'b1;
                end else begin
                    state_d = ST_R0;
                    ag_inc  = 1'b1;
                end
            end
            ST_R1: begin
                cmp_en     = rd_valid_q;
                cmp_data   = rd_data_q;
                cmp_exp    = ~PATTERN;
                cmp_addr   = rd_addr_q;
                rd_valid_d = 1'b1;
                rd_data_d  = ram_dout;
                rd_addr_d  = cur_addr;
                if (at_zero) begin
                    state_d    = ST_FLUSH;
                    ag_ld_zero = 1'b1;
                end else begin
                    ag_dec = 1'b1;
                end
            end
            ST_FLUSH: begin
                cmp_en   = rd_valid_q;
                cmp_data = rd_data_q;
                cmp_exp  = ~PATTERN;
                cmp_addr = rd_addr_q;
                state_d  = ST_DONE;
                busy_d   = 1'b0;
                done_d   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cmp_en && (cmp_data != cmp_exp)) begin
            if (err_q == '0) begin
                fail_addr_d = cmp_addr;
                fail_data_d = cmp_data;
                fail_exp_d  = cmp_exp;
            end
            if (err_q != '1) begin
                err_d = err_q + 1'b1;
            end
        end

        // Verdict includes the final compare made in this same cycle.
        if (state_q == ST_FLUSH) begin
            pass_d = (err_d == '0);
        end
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ram_r_w_q   <= 1'b0;
            ram_din_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_exp_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            ram_r_w_q   <= ram_r_w_d;
            ram_din_q   <= ram_din_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            fail_exp_q  <= fail_exp_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign fail_exp  = fail_exp_q;
    assign ram_r_w   = ram_r_w_q;
    assign ram_addr  = cur_addr;
    assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl with behavioural RAM models (optional faults).
module tb_mem_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fault  = 0;   // 0 good, 1 cell1 bit7 stuck-0, 2 cell0 stuck 00

    // DUT A: ADDR_W=1, PATTERN=AA
    logic       start1 = 1'b0;
    logic       busy1, done1, pass1, rw1;
    logic [2:0] err1;
    logic       faddr1, addr1;
    logic [7:0] fdata1, fexp1, din1;
    logic [7:0] dout1 = 8'h00;
    logic [7:0] mem1 [0:1];

    // DUT B: ADDR_W=3, PATTERN=3C
    logic       start3 = 1'b0;
    logic       busy3, done3, pass3, rw3;
    logic [4:0] err3;
    logic [2:0] faddr3, addr3;
    logic [7:0] fdata3, fexp3, din3;
    logic [7:0] dout3 = 8'h00;
    logic [7:0] mem3 [0:7];

    mem_bist_ctrl #(.ADDR_W(1), .DATA_W(8), .PATTERN(8'hAA)) dut (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_addr(faddr1), .fail_data(fdata1), .fail_exp(fexp1),
        .ram_r_w(rw1), .ram_addr(addr1), .ram_din(din1), .ram_dout(dout1)
    );

    mem_bist_ctrl #(.ADDR_W(3), .DATA_W(8), .PATTERN(8'h3C)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_addr(faddr3), .fail_data(fdata3), .fail_exp(fexp3),
        .ram_r_w(rw3), .ram_addr(addr3), .ram_din(din3), .ram_dout(dout3)
    );

    function automatic logic [7:0] flt1(input logic a, input logic [7:0] v);
        if (fault == 1 && a == 1'b1) return v & 8'h7F;
        if (fault == 2 && a == 1'b0) return 8'h00;
        return v;
    endfunction

    // RAM models: write at posedge ending a write cycle, read data at negedge, X while writing.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem1[0] <= 8'h00; mem1[1] <= 8'h00;
            for (int i = 0; i < 8; i++) mem3[i] <= 8'h00;
        end else begin
            if (rw1) mem1[addr1] <= din1;
            if (rw3) mem3[addr3] <= din3;
        end
    end

    always @(negedge clk) begin
        dout1 <= rw1 ? 8'hxx : flt1(addr1, mem1[addr1]);
        dout3 <= rw3 ? 8'hxx : mem3[addr3];
    end

    // Per-cycle RAM command logs.
    logic       log_rw[$];
    int         log_addr[$];
    logic [7:0] log_din[$];
    int         rd3_addr[$];
    always @(negedge clk) begin
        if (busy1) begin
            log_rw.push_back(rw1);
            log_addr.push_back(int'(addr1));
            log_din.push_back(din1);
        end
        if (busy3 && !rw3) rd3_addr.push_back(int'(addr3));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Raise start before an edge (t0); return #1 after t0.
    task automatic kick(input bit sel, input bit hold);
        @(negedge clk);
        if (sel) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        chk("busy_at_t0", sel ? busy3 : busy1, 1);
        if (!hold) begin
            if (sel) start3 = 1'b0; else start1 = 1'b0;
        end
    endtask

    // Count edges after t0 until done, bounded.
    task automatic wait_done(input bit sel, output int cyc);
        cyc = 0;
        while (cyc <= 60) begin
            @(posedge clk); #1;
            cyc++;
            if (sel ? done3 : done1) break;
        end
    endtask

    int cyc;
    int exp_rw   [8] = '{1, 1, 0, 1, 0, 1, 0, 0};
    int exp_addr [8] = '{0, 1, 0, 0, 1, 1, 1, 0};
    int exp_din  [8] = '{8'hAA, 8'hAA, 0, 8'h55, 0, 8'h55, 0, 0};

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", busy1, 0);   chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);   chk("rst_err", err1, 0);
        chk("rst_fail", {faddr1, fdata1, fexp1}, 0);
        chk("rst_ram", {rw1, addr1, din1}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Good RAM, command sequence and latency
        log_rw.delete(); log_addr.delete(); log_din.delete();
        kick(0, 0);
        wait_done(0, cyc);
        chk("good_latency", cyc, 9);
        chk("good_pass", pass1, 1);
        chk("good_err", err1, 0);
        chk("good_busy_low", busy1, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("seq_rw_%0d", i), log_rw[i], exp_rw[i]);
            chk($sformatf("seq_addr_%0d", i), log_addr[i], exp_addr[i]);
            if (exp_rw[i] == 1) chk($sformatf("seq_din_%0d", i), log_din[i], exp_din[i]);
        end

        // Cell 1 bit 7 stuck at 0
        fault = 1;
        kick(0, 0);
        wait_done(0, cyc);
        chk("sa0_latency", cyc, 9);
        chk("sa0_pass", pass1, 0);
        chk("sa0_err", err1, 1);
        chk("sa0_faddr", faddr1, 1);
        chk("sa0_fexp", fexp1, 8'hAA);
        chk("sa0_fdata", fdata1, 8'h2A);

        // Cell 0 stuck at 00, start held high through the run
        fault = 2;
        kick(0, 1);
        wait_done(0, cyc);
        chk("st00_latency_no_restart", cyc, 9);
        chk("st00_pass", pass1, 0);
        chk("st00_err", err1, 2);
        chk("st00_faddr", faddr1, 0);
        chk("st00_fexp", fexp1, 8'hAA);
        chk("st00_fdata", fdata1, 8'h00);
        // Held start: new run begins on the next edge with cleared results
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("restart_busy", busy1, 1);
        chk("restart_done", done1, 0);
        chk("restart_err_clr", err1, 0);
        chk("restart_fexp_clr", fexp1, 0);
        wait_done(0, cyc);
        chk("restart_latency", cyc, 9);
        chk("restart_err", err1, 2);

        // Mid-run asynchronous reset
        fault = 0;
        kick(0, 0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy1, 0);
        chk("midrst_done_pass", {done1, pass1}, 0);
        chk("midrst_err", err1, 0);
        chk("midrst_fail", {faddr1, fdata1, fexp1}, 0);
        chk("midrst_ram", {rw1, addr1, din1}, 0);
        @(negedge clk) rst = 1'b0;
        kick(0, 0);
        wait_done(0, cyc);
        chk("midrst_rerun_latency", cyc, 9);
        chk("midrst_rerun_pass", pass1, 1);

        // ADDR_W=3, PATTERN=3C
        rd3_addr.delete();
        kick(1, 0);
        wait_done(1, cyc);
        chk("sweep_latency", cyc, 33);
        chk("sweep_pass", pass3, 1);
        chk("sweep_err", err3, 0);
        chk("sweep_nreads", rd3_addr.size(), 17);
        for (int i = 0; i < 8; i++)
            chk($sformatf("sweep_r1_addr_%0d", i), rd3_addr[8 + i], 7 - i);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
